matmul_sequencer: RTL and testbench

Bus-master controller that drives the uint matrix-multiply accelerator through its memory-mapped port. It computes C = A·B for an M×N matrix A, with M up to MAX_ROWS. B is loaded once, then for each row of A the block writes the row, reads back the N-element result and stores it to a destination memory. A host starts it with a pulse and sees busy/done/err; word data comes from a source memory port.

---
 rtl/matmul_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Bus-master sequencer that streams B, then each row of A, through the matrix-multiply
// accelerator and copies every result row from the accelerator to destination memory.
module matmul_sequencer #(
  parameter int unsigned N            = 4,
  parameter int unsigned INPUT_WIDTH  = 8,
  parameter int unsigned RESULT_WIDTH = 8,
  parameter int unsigned MAX_ROWS     = 255,
  parameter logic [31:0] ACC_WRITE    = 32'h0110_0000,
  parameter logic [31:0] ACC_READ     = 32'h0130_0000,
  parameter int unsigned AW           = 16,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [7:0]    rows,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] c_base,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          src_req,
  output logic [AW-1:0] src_addr,
  input  logic          src_ready,
  input  logic [31:0]   src_rdata,
  output logic          dst_req,
  output logic [AW-1:0] dst_addr,
  output logic [31:0]   dst_wdata,
  input  logic          dst_ready,
  output logic          acc_valid,
  output logic [31:0]   acc_addr,
  output logic [31:0]   acc_wdata,
  output logic [3:0]    acc_wstrb,
  input  logic          acc_ready,
  input  logic [31:0]   acc_rdata
);

  localparam int unsigned A_WORDS = N * INPUT_WIDTH / 32;
  localparam int unsigned B_WORDS = N * N * INPUT_WIDTH / 32;
  localparam int unsigned C_WORDS = N * RESULT_WIDTH / 32;
  localparam int unsigned KMAX    = (B_WORDS > C_WORDS) ? B_WORDS : C_WORDS;
  localparam int unsigned KW      = $clog2(KMAX) + 1;
  localparam int unsigned TW      = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {IDLE, B_RD, B_WR, A_RD, A_WR, R_RD, R_WR, GAP, FIN} state_e;

  state_e        state_q, state_d, ret_q, ret_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]    r_q, r_d, rows_q, rows_d;
  logic [AW-1:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic [31:0]   data_q, data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  logic          tmo_hit, k_last_a, k_last_b, k_last_c;
  logic [AW-1:0] a_addr, c_addr;

  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
  assign k_last_a = (k_q == KW'(A_WORDS - 1));
  assign k_last_b = (k_q == KW'(B_WORDS - 1));
  assign k_last_c = (k_q == KW'(C_WORDS - 1));
  assign a_addr   = a_base_q + AW'(32'(r_q) * A_WORDS) + AW'(k_q);
  assign c_addr   = c_base_q + AW'(32'(r_q) * C_WORDS) + AW'(k_q);

  assign busy = (state_q != IDLE) && (state_q != FIN);
  assign done = (state_q == FIN);
  assign err  = err_q;

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    k_d       = k_q;
    r_d       = r_q;
    rows_d    = rows_q;
    a_base_d  = a_base_q;
    b_base_d  = b_base_q;
    c_base_d  = c_base_q;
    data_d    = data_q;
    err_d     = err_q;
    tmo_d     = '0;
    src_req   = 1'b0;
    src_addr  = '0;
    dst_req   = 1'b0;
    dst_addr  = '0;
    dst_wdata = '0;
    acc_valid = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    acc_wstrb = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (rows == '0 || 32'(rows) > MAX_ROWS) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            rows_d   = rows;
            a_base_d = a_base;
            b_base_d = b_base;
            c_base_d = c_base;
            err_d    = 1'b0;
            k_d      = '0;
            r_d      = '0;
            state_d  = B_RD;
          end
        end
      end
      B_RD, A_RD: begin
        src_req  = 1'b1;
        src_addr = (state_q == B_RD) ? b_base_q + AW'(k_q) : a_addr;
        if (src_ready) begin
          data_d  = src_rdata;
          state_d = (state_q == B_RD) ? B_WR : A_WR;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      // All accelerator requests share one wait/timeout path; the state after the
      // mandatory GAP cycle is decided here and parked in ret_q.
      B_WR, A_WR, R_RD: begin
        acc_valid = 1'b1;
        unique case (state_q)
          B_WR:    acc_addr = ACC_WRITE + ((A_WORDS + 32'(k_q)) << 2);
          A_WR:    acc_addr = ACC_WRITE + (32'(k_q) << 2);
          default: acc_addr = ACC_READ + (32'(k_q) << 2);
        endcase
        acc_wdata = (state_q == R_RD) ? '0 : data_q;
        acc_wstrb = (state_q == R_RD) ? 4'h0 : 4'hF;
        if (acc_ready) begin
          state_d = GAP;
          unique case (state_q)
            B_WR: begin
              k_d   = k_last_b ? '0 : k_q + 1'b1;
              ret_d = k_last_b ? A_RD : B_RD;
            end
            A_WR: begin
              k_d   = k_last_a ? '0 : k_q + 1'b1;
              ret_d = k_last_a ? R_RD : A_RD;
            end
            default: begin
              data_d = acc_rdata;
              ret_d  = R_WR;
            end
          endcase
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      R_WR: begin
        dst_req   = 1'b1;
        dst_addr  = c_addr;
        dst_wdata = data_q;
        if (dst_ready) begin
          if (k_last_c) begin
            k_d     = '0;
            r_d     = r_q + 8'd1;
            state_d = (r_d == rows_q) ? FIN : A_RD;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = R_RD;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP:     state_d = ret_q;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ret_q    <= IDLE;
      k_q      <= '0;
      r_q      <= '0;
      rows_q   <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      data_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      k_q      <= k_d;
      r_q      <= r_d;
      rows_q   <= rows_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      data_q   <= data_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: memory and accelerator models around the DUT,
// hand-computed results, cycle counts (start cycle counted as cycle 1) and hold checks.
module tb_matmul_sequencer;

  localparam logic [31:0] ACC_WRITE = 32'h0110_0000;
  localparam logic [31:0] ACC_READ  = 32'h0130_0000;
  localparam int          AW        = 16;
  localparam logic [15:0] A_BASE    = 16'h0010;
  localparam logic [15:0] B_BASE    = 16'h0020;
  localparam logic [15:0] C_BASE    = 16'h0100;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rows = '0;
  logic [AW-1:0] a_base = '0, b_base = '0, c_base = '0;
  logic          busy, done, err;
  logic          src_req, src_ready;
  logic [AW-1:0] src_addr;
  logic [31:0]   src_rdata;
  logic          dst_req, dst_ready;
  logic [AW-1:0] dst_addr;
  logic [31:0]   dst_wdata;
  logic          acc_valid;
  logic [31:0]   acc_addr, acc_wdata, acc_rdata;
  logic [3:0]    acc_wstrb;
  logic          acc_ready = 1'b0;

  logic [31:0] smem [0:1023];
  logic [31:0] cmem [0:1023];
  logic [31:0] acc_a = '0;
  logic [31:0] acc_b [0:3] = '{default: '0};

  int src_stall = 0, dst_stall = 0, acc_delay = 0;
  bit acc_stuck = 1'b0;
  int scnt = 0, dcnt = 0, acnt = 0;
  int checks = 0, errors = 0;
  int hold_viol = 0, bus_cycles = 0, accv_cycles = 0;

  logic          sw_p = 1'b0, dw_p = 1'b0, aw_p = 1'b0;
  logic [AW-1:0] sa_p = '0, da_p = '0;
  logic [31:0]   dd_p = '0, aa_p = '0, ad_p = '0;
  logic [3:0]    as_p = '0;

  int   cyc, seen, guard;
  logic e_r, b_done, b_first, rd_prev;

  always #5 clk = ~clk;

  matmul_sequencer #(.TIMEOUT(15)) dut (
    .clk(clk), .resetn(resetn), .start(start), .rows(rows),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .busy(busy), .done(done), .err(err),
    .src_req(src_req), .src_addr(src_addr), .src_ready(src_ready), .src_rdata(src_rdata),
    .dst_req(dst_req), .dst_addr(dst_addr), .dst_wdata(dst_wdata), .dst_ready(dst_ready),
    .acc_valid(acc_valid), .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_wstrb(acc_wstrb),
    .acc_ready(acc_ready), .acc_rdata(acc_rdata)
  );

  // Reference product of one A row with column-major B, 8-bit wrapping sums.
  function automatic logic [31:0] mat_row(input logic [31:0] a, input logic [127:0] b);
    logic [7:0] s;
    mat_row = '0;
    for (int k = 0; k < 4; k++) begin
      s = '0;
      for (int j = 0; j < 4; j++) s = s + a[8*j +: 8] * b[32*k + 8*j +: 8];
      mat_row[8*k +: 8] = s;
    end
  endfunction

  assign src_ready = src_req && (scnt >= src_stall);
  assign src_rdata = smem[src_addr[9:0]];
  assign dst_ready = dst_req && (dcnt >= dst_stall);
  assign acc_rdata = (acc_addr == ACC_READ) ? mat_row(acc_a, {acc_b[3], acc_b[2], acc_b[1], acc_b[0]}) : '0;

  always @(posedge clk) begin
    scnt      <= (src_req && !src_ready) ? scnt + 1 : 0;
    dcnt      <= (dst_req && !dst_ready) ? dcnt + 1 : 0;
    acnt      <= acc_valid ? acnt + 1 : 0;
    acc_ready <= acc_valid && !acc_stuck && (acnt >= acc_delay);
    if (dst_req && dst_ready) cmem[dst_addr[9:0]] <= dst_wdata;
    if (acc_valid && acc_ready && acc_wstrb == 4'hF) begin
      case (acc_addr - ACC_WRITE)
        32'd0:   acc_a    <= acc_wdata;
        32'd4:   acc_b[0] <= acc_wdata;
        32'd8:   acc_b[1] <= acc_wdata;
        32'd12:  acc_b[2] <= acc_wdata;
        32'd16:  acc_b[3] <= acc_wdata;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (src_req || dst_req || acc_valid) bus_cycles <= bus_cycles + 1;
    if (acc_valid) accv_cycles <= accv_cycles + 1;
    if ((sw_p && (!src_req || src_addr != sa_p)) ||
        (dw_p && (!dst_req || dst_addr != da_p || dst_wdata != dd_p)) ||
        (aw_p && (!acc_valid || acc_addr != aa_p || acc_wdata != ad_p || acc_wstrb != as_p)))
      hold_viol <= hold_viol + 1;
    sw_p <= src_req && !src_ready;
    dw_p <= dst_req && !dst_ready;
    aw_p <= acc_valid && !acc_ready;
    sa_p <= src_addr;
    da_p <= dst_addr;
    dd_p <= dst_wdata;
    aa_p <= acc_addr;
    ad_p <= acc_wdata;
    as_p <= acc_wstrb;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_ident();
    smem[A_BASE]     = 32'h0403_0201;
    smem[A_BASE + 1] = 32'h0807_0605;
    smem[B_BASE]     = 32'h0000_0001;
    smem[B_BASE + 1] = 32'h0000_0100;
    smem[B_BASE + 2] = 32'h0001_0000;
    smem[B_BASE + 3] = 32'h0100_0000;
  endtask

  task automatic load_twos(input logic [31:0] a);
    smem[A_BASE] = a;
    for (int i = 0; i < 4; i++) smem[B_BASE + i] = 32'h0202_0202;
  endtask

  // Cycle count: the cycle with start high is 1, the cycle with done high is returned.
  task automatic run(input logic [7:0] m, output int n, output logic e, output logic bd,
                     output logic bf);
    @(posedge clk);
    #1;
    hold_viol = 0;
    bus_cycles = 0;
    accv_cycles = 0;
    for (int i = 0; i < 1024; i++) cmem[i] = '0;
    @(negedge clk);
    rows = m; a_base = A_BASE; b_base = B_BASE; c_base = C_BASE; start = 1'b1;
    n = 1;
    @(negedge clk);
    start = 1'b0;
    n = 2;
    bf = busy;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
    e  = err;
    bd = busy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) smem[i] = 32'hDEAD_0000 | i;
    repeat (2) @(negedge clk);
    check("rst_ctl", {26'b0, busy, done, err, src_req, dst_req, acc_valid}, 32'h0);
    check("rst_acc_addr", acc_addr, 32'h0);
    check("rst_data", acc_wdata | dst_wdata | {28'b0, acc_wstrb}, 32'h0);
    check("rst_addrs", {src_addr, dst_addr}, 32'h0);
    resetn = 1'b1;

    // Identity B
    load_ident();
    run(8'd2, cyc, e_r, b_done, b_first);
    check("t1_cycles", cyc, 34);
    check("t1_err", e_r, 1'b0);
    check("t1_busy_start", b_first, 1'b1);
    check("t1_busy_done", b_done, 1'b0);
    check("t1_c0", cmem[C_BASE], 32'h0403_0201);
    check("t1_c1", cmem[C_BASE + 1], 32'h0807_0605);
    @(negedge clk);
    check("t1_done_pulse", done, 1'b0);

    // All-2 matrices, then 8-bit wrap
    load_twos(32'h0202_0202);
    run(8'd1, cyc, e_r, b_done, b_first);
    check("t2_cycles", cyc, 26);
    check("t2_c0", cmem[C_BASE], 32'h1010_1010);
    load_twos(32'h4040_4040);
    smem[C_BASE] = 32'h0;
    run(8'd1, cyc, e_r, b_done, b_first);
    check("t2_wrap_c0", cmem[C_BASE], 32'h0000_0000);
    check("t2_wrap_err", e_r, 1'b0);

    // rows = 0
    run(8'd0, cyc, e_r, b_done, b_first);
    check("t3_cycles", cyc, 2);
    check("t3_err", e_r, 1'b1);
    check("t3_bus", bus_cycles, 0);
    @(negedge clk);
    check("t3_err_held", err, 1'b1);

    // Backpressure: 6 src reads + 2 dst writes at 3 stalls, 8 acc transactions at 2
    load_ident();
    src_stall = 3; dst_stall = 3; acc_delay = 2;
    run(8'd2, cyc, e_r, b_done, b_first);
    check("t4_cycles", cyc, 74);
    check("t4_err", e_r, 1'b0);
    check("t4_c0", cmem[C_BASE], 32'h0403_0201);
    check("t4_c1", cmem[C_BASE + 1], 32'h0807_0605);
    check("t4_hold", hold_viol, 0);
    src_stall = 0; dst_stall = 0; acc_delay = 0;

    // Stuck accelerator
    acc_stuck = 1'b1;
    run(8'd1, cyc, e_r, b_done, b_first);
    check("t5_cycles", cyc, 18);
    check("t5_err", e_r, 1'b1);
    check("t5_busy", b_done, 1'b0);
    check("t5_accv", accv_cycles, 15);
    acc_stuck = 1'b0;
    run(8'd2, cyc, e_r, b_done, b_first);
    check("t5_rerun_cycles", cyc, 34);
    check("t5_rerun_err", e_r, 1'b0);
    check("t5_rerun_c1", cmem[C_BASE + 1], 32'h0807_0605);

    // Reset during the row-1 result read
    @(negedge clk);
    rows = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0; guard = 0; rd_prev = 1'b0;
    while (seen < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (acc_valid && acc_addr == ACC_READ && !rd_prev) seen++;
      rd_prev = acc_valid && (acc_addr == ACC_READ);
    end
    check("t6_row1_read", seen, 2);
    #2 resetn = 1'b0;
    #1;
    check("t6_acc_valid", acc_valid, 1'b0);
    check("t6_ctl", {26'b0, busy, done, err, src_req, dst_req, acc_valid}, 32'h0);
    check("t6_addr", acc_addr | {16'b0, src_addr} | {16'b0, dst_addr}, 32'h0);
    @(negedge clk);
    check("t6_no_done", done, 1'b0);
    resetn = 1'b1;
    run(8'd2, cyc, e_r, b_done, b_first);
    check("t6_cycles", cyc, 34);
    check("t6_c0", cmem[C_BASE], 32'h0403_0201);
    check("t6_c1", cmem[C_BASE + 1], 32'h0807_0605);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
